// File: rtl/prime_sieve.sv
// Sieve of Eratosthenes over 0..N. Builds a 1-bit primality table in an internal
// synchronous-read memory, counts the primes, then answers in-order primality queries.
module prime_sieve #(
  parameter int N  = 1000,
  parameter int AW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] prime_count,
  input  logic          q_req,
  input  logic [AW-1:0] q_addr,
  output logic          q_rsp_valid,
  output logic          q_is_prime,
  output logic          q_err,
  output logic [2:0]    o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_SCAN_RD  = 3'd2,
    S_SCAN_CHK = 3'd3,
    S_MARK     = 3'd4,
    S_COUNT    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [AW-1:0]   N_A  = AW'(N);
  localparam logic [AW:0]     N_J  = (AW + 1)'(N);
  localparam logic [AW:0]     N_J1 = (AW + 1)'(N + 1);
  localparam logic [2*AW-1:0] N_W  = (2 * AW)'(N);

  state_t r_state;
  state_t w_next;

  logic [AW:0]     r_addr;
  logic [AW-1:0]   r_i;
  logic [AW:0]     r_j;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   r_prime_count;
  logic            r_mem [0:N];
  logic            r_rd_data;

  logic            r_q_v1;
  logic            r_q_err1;
  logic            r_q_rsp_valid;
  logic            r_q_is_prime;
  logic            r_q_err;

  logic            w_we;
  logic            w_wd;
  logic [AW-1:0]   w_wa;
  logic [AW-1:0]   w_ra;
  logic [2*AW-1:0] w_ii;
  logic            w_ii_gt_n;

  assign w_ii      = {{AW{1'b0}}, r_i} * {{AW{1'b0}}, r_i};
  assign w_ii_gt_n = (w_ii > N_W);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    o_dbg_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_INIT;
      end
      S_INIT: begin
        busy = 1'b1;
        if (r_addr == N_J) w_next = S_SCAN_RD;
      end
      S_SCAN_RD: begin
        busy   = 1'b1;
        w_next = w_ii_gt_n ? S_COUNT : S_SCAN_CHK;
      end
      S_SCAN_CHK: begin
        busy   = 1'b1;
        w_next = r_rd_data ? S_MARK : S_SCAN_RD;
      end
      S_MARK: begin
        busy = 1'b1;
        if (r_j > N_J) w_next = S_SCAN_RD;
      end
      S_COUNT: begin
        busy = 1'b1;
        if (r_addr == N_J1) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_INIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Single read port: the sequencer owns it while building, the query path only in DONE.
  always_comb begin
    w_we = 1'b0;
    w_wd = 1'b0;
    w_wa = '0;
    w_ra = '0;
    case (r_state)
      S_INIT: begin
        w_we = 1'b1;
        w_wa = r_addr[AW-1:0];
        w_wd = (r_addr[AW:1] != '0);
      end
      S_SCAN_RD: w_ra = r_i;
      S_MARK: begin
        if (r_j <= N_J) begin
          w_we = 1'b1;
          w_wa = r_j[AW-1:0];
        end
      end
      S_COUNT: w_ra = (r_addr <= N_J) ? r_addr[AW-1:0] : '0;
      S_DONE:  w_ra = (q_addr <= N_A) ? q_addr : '0;
      default: ;
    endcase
  end

  // Flag memory and its read register carry no reset; contents are valid only after a build.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wa] <= w_wd;
    r_rd_data <= r_mem[w_ra];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr        <= '0;
      r_i           <= '0;
      r_j           <= '0;
      r_cnt         <= '0;
      r_prime_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_addr        <= '0;
            r_prime_count <= '0;
          end
        end
        S_INIT: begin
          if (r_addr == N_J) r_i <= AW'(2);
          else               r_addr <= r_addr + 1'b1;
        end
        S_SCAN_RD: begin
          if (w_ii_gt_n) begin
            r_addr <= '0;
            r_cnt  <= '0;
          end
        end
        S_SCAN_CHK: begin
          if (r_rd_data) r_j <= w_ii[AW:0];
          else           r_i <= r_i + 1'b1;
        end
        S_MARK: begin
          if (r_j <= N_J) r_j <= r_j + {1'b0, r_i};
          else            r_i <= r_i + 1'b1;
        end
        S_COUNT: begin
          // r_rd_data holds flag[r_addr-1]; the final cycle only drains the last read.
          if (r_addr == N_J1) begin
            r_prime_count <= r_cnt + {{(AW-1){1'b0}}, r_rd_data};
          end else begin
            r_addr <= r_addr + 1'b1;
            if (r_addr != '0) r_cnt <= r_cnt + {{(AW-1){1'b0}}, r_rd_data};
          end
        end
        default: ;
      endcase
    end
  end

  // Query protocol: q_req has no backpressure and is accepted every cycle; each accepted
  // request yields exactly one q_rsp_valid pulse two cycles later, in request order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q_v1        <= 1'b0;
      r_q_err1      <= 1'b0;
      r_q_rsp_valid <= 1'b0;
      r_q_is_prime  <= 1'b0;
      r_q_err       <= 1'b0;
    end else begin
      r_q_v1        <= q_req;
      r_q_err1      <= (r_state != S_DONE) || (q_addr > N_A);
      r_q_rsp_valid <= r_q_v1;
      r_q_err       <= r_q_v1 & r_q_err1;
      r_q_is_prime  <= r_q_v1 & ~r_q_err1 & r_rd_data;
    end
  end

  assign prime_count = r_prime_count;
  assign q_rsp_valid = r_q_rsp_valid;
  assign q_is_prime  = r_q_is_prime;
  assign q_err       = r_q_err;

endmodule
